// File: rtl/raw_fwd_pkg.sv
// Shared widths, writeback stage record and operand-source encodings
// for the RAW forwarding unit.
package raw_fwd_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } stage_t;

  typedef enum logic [1:0] {
    SRC_RF = 2'b00,
    SRC_S1 = 2'b01,
    SRC_S2 = 2'b10,
    SRC_X0 = 2'b11
  } fwd_src_e;

endpackage

// File: rtl/fwd_select.sv
// Combinational operand selector: x0, then the younger stage, then the
// older stage, then the register-file read data.
module fwd_select
  import raw_fwd_pkg::*;
#(
  parameter int unsigned XLEN   = raw_fwd_pkg::XLEN,
  parameter int unsigned REG_AW = raw_fwd_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] i_addr,
  input  logic [XLEN-1:0]   i_rf_val,
  input  stage_t            i_s1,
  input  stage_t            i_s2,
  output logic [XLEN-1:0]   o_val,
  output logic [1:0]        o_src
);

  logic w_s1_hit;
  logic w_s2_hit;

  // A non-zero address match also guarantees the stage never forwards rd=0.
  assign w_s1_hit = i_s1.valid && (i_s1.rd == i_addr);
  assign w_s2_hit = i_s2.valid && (i_s2.rd == i_addr);

  always_comb begin
    o_val = i_rf_val;
    o_src = SRC_RF;
    if (i_addr == '0) begin
      o_val = '0;
      o_src = SRC_X0;
    end else if (w_s1_hit) begin
      o_val = i_s1.data;
      o_src = SRC_S1;
    end else if (w_s2_hit) begin
      o_val = i_s2.data;
      o_src = SRC_S2;
    end
  end

endmodule

// File: rtl/raw_forward_unit.sv
// Two-stage writeback pipeline with read-after-write operand forwarding
// and register-file commit from the older stage.
module raw_forward_unit
  import raw_fwd_pkg::*;
#(
  parameter int unsigned XLEN   = raw_fwd_pkg::XLEN,
  parameter int unsigned REG_AW = raw_fwd_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              hold,
  input  logic              flush,
  input  logic [REG_AW-1:0] DCR_rs1,
  input  logic [REG_AW-1:0] DCR_rs2,
  input  logic [XLEN-1:0]   rf_rs1_val,
  input  logic [XLEN-1:0]   rf_rs2_val,
  output logic [XLEN-1:0]   RAW_rs1_val,
  output logic [XLEN-1:0]   RAW_rs2_val,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [XLEN-1:0]   rf_wr_data,
  output logic [1:0]        TRACE_rs1_src,
  output logic [1:0]        TRACE_rs2_src
);

  stage_t r_s1;
  stage_t r_s2;
  stage_t w_s1_next;

  // A flushed result still advances, but as a bubble.
  always_comb begin
    w_s1_next       = '0;
    w_s1_next.valid = alu_valid & ~flush;
    w_s1_next.rd    = alu_rd;
    w_s1_next.data  = alu_result;
  end

  // Writeback stages; hold freezes both regardless of flush/alu_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (!hold) begin
      r_s1 <= w_s1_next;
      r_s2 <= r_s1;
    end
  end

  assign rf_wr_en   = r_s2.valid & (r_s2.rd != '0) & ~hold;
  assign rf_wr_addr = r_s2.rd;
  assign rf_wr_data = r_s2.data;

  fwd_select #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs1 (
    .i_addr   (DCR_rs1),
    .i_rf_val (rf_rs1_val),
    .i_s1     (r_s1),
    .i_s2     (r_s2),
    .o_val    (RAW_rs1_val),
    .o_src    (TRACE_rs1_src)
  );

  fwd_select #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs2 (
    .i_addr   (DCR_rs2),
    .i_rf_val (rf_rs2_val),
    .i_s1     (r_s1),
    .i_s2     (r_s2),
    .o_val    (RAW_rs2_val),
    .o_src    (TRACE_rs2_src)
  );

endmodule

// File: tb/tb_raw_forward_unit.sv
// Bench for raw_forward_unit: history-of-offers model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_raw_forward_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        hold;
  logic        flush;
  logic [4:0]  DCR_rs1;
  logic [4:0]  DCR_rs2;
  logic [31:0] rf_rs1_val;
  logic [31:0] rf_rs2_val;
  logic [31:0] RAW_rs1_val;
  logic [31:0] RAW_rs2_val;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [1:0]  TRACE_rs1_src;
  logic [1:0]  TRACE_rs2_src;

  int nchk = 0;
  int nfail = 0;
  int wr_cnt[32] = '{default: 0};

  raw_forward_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_result    (alu_result),
    .hold          (hold),
    .flush         (flush),
    .DCR_rs1       (DCR_rs1),
    .DCR_rs2       (DCR_rs2),
    .rf_rs1_val    (rf_rs1_val),
    .rf_rs2_val    (rf_rs2_val),
    .RAW_rs1_val   (RAW_rs1_val),
    .RAW_rs2_val   (RAW_rs2_val),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data),
    .TRACE_rs1_src (TRACE_rs1_src),
    .TRACE_rs2_src (TRACE_rs2_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, recognisable register-file read data per port and address.
  assign rf_rs1_val = 32'hA000_0000 | 32'(DCR_rs1);
  assign rf_rs2_val = 32'hB000_0000 | 32'(DCR_rs2);

  typedef struct {
    bit          v;
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  // Newest first: the last two unheld-cycle ALU offers since reset.
  ent_t hist[$];

  always @(posedge clk or negedge rst_n) begin
    ent_t e;
    if (!rst_n) begin
      hist.delete();
    end else if (!hold) begin
      e.v  = alu_valid && !flush;
      e.rd = alu_rd;
      e.d  = alu_result;
      hist.push_front(e);
      if (hist.size() > 2) void'(hist.pop_back());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Youngest live offer for this register wins; x0 is always zero.
  function automatic void exp_fwd(input logic [4:0] a, input logic [31:0] rf,
                                  output logic [31:0] val, output logic [1:0] src);
    val = rf;
    src = 2'd0;
    if (a == 5'd0) begin
      val = 32'd0;
      src = 2'd3;
    end else begin
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i].v && hist[i].rd == a) begin
          val = hist[i].d;
          src = 2'(i + 1);
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] ev;
    logic [1:0]  es;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    exp_fwd(DCR_rs1, rf_rs1_val, ev, es);
    chk("model_rs1_val", RAW_rs1_val, ev);
    chk("model_rs1_src", 32'(TRACE_rs1_src), 32'(es));
    exp_fwd(DCR_rs2, rf_rs2_val, ev, es);
    chk("model_rs2_val", RAW_rs2_val, ev);
    chk("model_rs2_src", 32'(TRACE_rs2_src), 32'(es));
    ew = 1'b0;
    ea = 5'd0;
    ed = 32'd0;
    if (hist.size() == 2) begin
      ew = hist[1].v && hist[1].rd != 5'd0 && !hold;
      ea = hist[1].rd;
      ed = hist[1].d;
    end
    chk("model_wr_en", 32'(rf_wr_en), 32'(ew));
    chk("model_wr_addr", 32'(rf_wr_addr), 32'(ea));
    chk("model_wr_data", rf_wr_data, ed);
    if (rf_wr_en === 1'b1) wr_cnt[rf_wr_addr]++;
  end

  // Apply one cycle of inputs shortly after the rising edge, then let it settle.
  task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                      input logic h, input logic f, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    alu_valid  = v;
    alu_rd     = rd;
    alu_result = d;
    hold       = h;
    flush      = f;
    DCR_rs1    = a1;
    DCR_rs2    = a2;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd2);
  endtask

  int c3, c4, c6, c9, c10, c11, ctot;

  initial begin
    rst_n      = 1'b0;
    alu_valid  = 1'b0;
    alu_rd     = 5'd0;
    alu_result = 32'd0;
    hold       = 1'b0;
    flush      = 1'b0;
    DCR_rs1    = 5'd3;
    DCR_rs2    = 5'd0;
    #2;
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("rst_wr_data", rf_wr_data, 32'd0);
    chk("rst_rs1_val", RAW_rs1_val, 32'hA000_0003);
    chk("rst_rs1_src", 32'(TRACE_rs1_src), 32'd0);
    chk("rst_rs2_val", RAW_rs2_val, 32'd0);
    chk("rst_rs2_src", 32'(TRACE_rs2_src), 32'd3);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Back-to-back dependency on x5
    step(1'b1, 5'd5, 32'h0000_0011, 1'b0, 1'b0, 5'd1, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd5);
    chk("b2b_s1_val", RAW_rs2_val, 32'h11);
    chk("b2b_s1_src", 32'(TRACE_rs2_src), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd5);
    chk("b2b_s2_val", RAW_rs2_val, 32'h11);
    chk("b2b_s2_src", 32'(TRACE_rs2_src), 32'd2);
    chk("b2b_wr_en", 32'(rf_wr_en), 32'd1);
    chk("b2b_wr_addr", 32'(rf_wr_addr), 32'd5);
    chk("b2b_wr_data", rf_wr_data, 32'h11);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd5);
    chk("b2b_rf_val", RAW_rs2_val, 32'hB000_0005);
    chk("b2b_rf_src", 32'(TRACE_rs2_src), 32'd0);
    chk("b2b_once", 32'(wr_cnt[5]), 32'd1);

    // Youngest wins on a double write to x7
    step(1'b1, 5'd7, 32'hAAAA_AAAA, 1'b0, 1'b0, 5'd1, 5'd2);
    step(1'b1, 5'd7, 32'h5555_5555, 1'b0, 1'b0, 5'd1, 5'd2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd7, 5'd7);
    chk("prio_rs1_val", RAW_rs1_val, 32'h5555_5555);
    chk("prio_rs1_src", 32'(TRACE_rs1_src), 32'd1);
    chk("prio_rs2_val", RAW_rs2_val, 32'h5555_5555);
    chk("prio_rs2_src", 32'(TRACE_rs2_src), 32'd1);
    idle(3);

    // A result to x0 never forwards and never writes
    ctot = 0;
    foreach (wr_cnt[i]) ctot += wr_cnt[i];
    step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd1, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd0);
    chk("x0_val", RAW_rs2_val, 32'd0);
    chk("x0_src", 32'(TRACE_rs2_src), 32'd3);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd0);
    chk("x0_no_wr", 32'(rf_wr_en), 32'd0);
    idle(2);
    foreach (wr_cnt[i]) ctot -= wr_cnt[i];
    chk("x0_no_writes", 32'(ctot), 32'd0);

    // Hold freezes the pipeline, then a flushed x4 is dropped
    c3 = wr_cnt[3];
    c4 = wr_cnt[4];
    c6 = wr_cnt[6];
    step(1'b1, 5'd3, 32'h1, 1'b0, 1'b0, 5'd1, 5'd2);
    step(1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 5'd3, 5'd6);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3, 5'd6);
      chk("hold_rs1_val", RAW_rs1_val, 32'h1);
      chk("hold_rs1_src", 32'(TRACE_rs1_src), 32'd1);
      chk("hold_rs2_src", 32'(TRACE_rs2_src), 32'd0);
      chk("hold_wr_en", 32'(rf_wr_en), 32'd0);
    end
    step(1'b1, 5'd4, 32'h2, 1'b0, 1'b1, 5'd3, 5'd4);
    chk("flush_rs1_src", 32'(TRACE_rs1_src), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd4);
    chk("flush_rs1_src2", 32'(TRACE_rs1_src), 32'd2);
    chk("flush_rs2_src", 32'(TRACE_rs2_src), 32'd0);
    chk("flush_wr_addr", 32'(rf_wr_addr), 32'd3);
    chk("flush_wr_en", 32'(rf_wr_en), 32'd1);
    idle(3);
    chk("x3_once", 32'(wr_cnt[3] - c3), 32'd1);
    chk("x4_never", 32'(wr_cnt[4] - c4), 32'd0);
    chk("x6_never", 32'(wr_cnt[6] - c6), 32'd0);

    // Asynchronous reset with both stages live
    c9  = wr_cnt[9];
    c10 = wr_cnt[10];
    step(1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 5'd1, 5'd2);
    step(1'b1, 5'd10, 32'hAA, 1'b0, 1'b0, 5'd1, 5'd2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd9, 5'd10);
    chk("pre_rst_rs2_val", RAW_rs2_val, 32'hAA);
    chk("pre_rst_rs1_src", 32'(TRACE_rs1_src), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("arst_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("arst_wr_data", rf_wr_data, 32'd0);
    chk("arst_rs1_val", RAW_rs1_val, 32'hA000_0009);
    chk("arst_rs1_src", 32'(TRACE_rs1_src), 32'd0);
    chk("arst_rs2_val", RAW_rs2_val, 32'hB000_000A);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    chk("arst_x9_dropped", 32'(wr_cnt[9] - c9), 32'd0);
    chk("arst_x10_dropped", 32'(wr_cnt[10] - c10), 32'd0);
    c11 = wr_cnt[11];
    step(1'b1, 5'd11, 32'hBB, 1'b0, 1'b0, 5'd1, 5'd2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd11, 5'd2);
    chk("post_rst_wr_en0", 32'(rf_wr_en), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd11, 5'd2);
    chk("post_rst_wr_en", 32'(rf_wr_en), 32'd1);
    chk("post_rst_wr_addr", 32'(rf_wr_addr), 32'd11);
    chk("post_rst_wr_data", rf_wr_data, 32'hBB);
    idle(2);
    chk("post_rst_once", 32'(wr_cnt[11] - c11), 32'd1);

    // Mixed traffic over a few registers, checked by the model each cycle
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), $urandom(),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
           5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/raw_forward_unit.md
RAW_FORWARD_UNIT -- requirements
Module: raw_forward_unit

Interface
REQ-001 Parameter XLEN, default 32: datapath width of results and operand values.
REQ-002 Parameter REG_AW, default 5: register address width, giving 32 architectural registers.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Ports for the ALU result:
- alu_valid, input, 1: the ALU result this cycle is architectural.
- alu_rd, input, REG_AW: destination register.
- alu_result, input, XLEN: result value.
REQ-006 Ports for pipeline control:
- hold, input, 1: freeze the writeback pipeline.
- flush, input, 1: kill the youngest in-flight result.
REQ-007 Ports for the decoded source operands:
- DCR_rs1, DCR_rs2, input, REG_AW: source register addresses.
- rf_rs1_val, rf_rs2_val, input, XLEN: register-file read data.
REQ-008 Ports for the forwarded operands: RAW_rs1_val, RAW_rs2_val, output, XLEN. These are the hazard-resolved operand values; RAW_rs2_val feeds the ALU operand-B immediate/register mux.
REQ-009 Ports for the register-file write: rf_wr_en, output, 1; rf_wr_addr, output, REG_AW; rf_wr_data, output, XLEN.
REQ-010 Ports for trace: TRACE_rs1_src and TRACE_rs2_src, output, 2: operand source encoding.
- 00 = RF
- 01 = S1
- 10 = S2
- 11 = x0

Function
REQ-011 The block SHALL hold two registered writeback stages, S1 (younger) and S2 (older); each stage holds {valid, rd, data}.
REQ-012 On each clk edge with hold=0, S1 SHALL load {alu_valid & ~flush, alu_rd, alu_result}, and S2 SHALL load S1 unchanged.
REQ-013 With hold=1, S1 and S2 SHALL retain their contents; hold overrides flush and alu_valid.
REQ-014 rf_wr_en SHALL equal S2.valid & (S2.rd != 0) & ~hold, combinationally. rf_wr_addr SHALL equal S2.rd and rf_wr_data SHALL equal S2.data, both direct from registers.
REQ-015 A result therefore SHALL commit to the register file exactly 2 unheld cycles after acceptance, and exactly once.
REQ-016 Forwarding for each operand SHALL be combinational, with this priority:
- address==0 gives 0 (src 11);
- else S1.valid & S1.rd==address gives S1.data (src 01);
- else S2.valid & S2.rd==address gives S2.data (src 10);
- else rf value (src 00).
REQ-017 S1 SHALL beat S2 when both match the same register (youngest wins).
REQ-018 A stage with valid=1 and rd=0 SHALL never forward and never write.
REQ-019 alu_result presented in the current cycle SHALL NOT be forwarded in that same cycle.
REQ-020 flush=1 with alu_valid=1 SHALL load S1 invalid; the S2 commit SHALL proceed normally.
REQ-021 The rs1 and rs2 paths SHALL be independent, and both may select the same stage in the same cycle.

Reset
REQ-022 rst_n low SHALL immediately clear S1 and S2 (valid, rd, data) to 0, without waiting for clk.
REQ-023 During reset:
- rf_wr_en, rf_wr_addr and rf_wr_data SHALL be 0;
- the RAW outputs SHALL show the rf values (or 0 for x0);
- the TRACE outputs SHALL be 00, or 11 for x0.
REQ-024 Reset asserted mid-operation SHALL discard in-flight results without committing them. The first result after deassertion SHALL follow REQ-015.

Structure
REQ-025 Shared package raw_fwd_pkg SHALL hold XLEN, REG_AW, the stage record typedef and the 2-bit source encodings.
REQ-026 The operand compare/priority logic SHALL be a sub-module fwd_select, instantiated once per operand.
REQ-027 All state SHALL reside in raw_forward_unit; fwd_select SHALL be purely combinational.

Verification
REQ-028 Back-to-back dependency: accept x5=0x0000_0011, then DCR_rs2=5 the next cycle -> RAW_rs2_val=0x11, TRACE_rs2_src=01. One cycle later -> 0x11, src 10. The cycle after -> rf_wr_en=1, addr 5, data 0x11 had already occurred; src 00.
REQ-029 Priority: accept x7=0xAAAA_AAAA then x7=0x5555_5555 -> DCR_rs1=DCR_rs2=7 gives 0x5555_5555 on both, src 01.
REQ-030 x0: accept rd=0, data 0xDEAD_BEEF -> never rf_wr_en; DCR_rs2=0 gives 0, src 11.
REQ-031 Hold/flush:
- accept x3=0x1, then hold for 3 cycles -> stages frozen, rf_wr_en=0, forwarding steady;
- then flush with alu_valid=1 (x4=0x2) -> x4 never written; x3 written once.
REQ-032 Reset: assert rst_n=0 asynchronously, mid-cycle, with S1 and S2 valid -> outputs zero immediately, no commit; after release, normal operation.
